tdm_demux8: RTL

- Receive end of the team's time-division multiplexed serial link: one bit per slot, NCH slots per frame, slot 0 flagged by fsync.
- Acquires frame alignment and routes slot k to channel k.
- Presents each completed frame as a parallel word with a one-cycle valid strobe.
- Flags framing violations and re-acquires alignment on its own.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_demux8_if.sv | 32 +++
 rtl/tdm_slot_ctr.sv | 25 ++
 rtl/tdm_demux8.sv | 113 +++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the tdm_demux8 receive path.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int NCH_DEF   = 8;
    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/tdm_demux8_if.sv
// Serial-in / parallel-out bundle for the TDM demux.
// err_cnt exists only when TDM_ERR_CNT_EN is defined.
interface tdm_demux8_if import tdm_pkg::*; #(parameter int NCH = NCH_DEF) ();

    logic           in_valid;
    logic           din;
    logic           fsync;
    logic [NCH-1:0] dout;
    logic           dout_valid;
    logic           locked;
    logic           sync_err;
`ifdef TDM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;
`endif

    modport master (
        output in_valid, din, fsync,
`ifdef TDM_ERR_CNT_EN
        input  err_cnt,
`endif
        input  dout, dout_valid, locked, sync_err
    );

    modport slave (
        input  in_valid, din, fsync,
`ifdef TDM_ERR_CNT_EN
        output err_cnt,
`endif
        output dout, dout_valid, locked, sync_err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear/wrap to 0, load to 1 on frame start, or step by one.
module tdm_slot_ctr #(parameter int SEL_W = 3) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_one,
    input  logic             wrap,
    input  logic             incr,
    output logic [SEL_W-1:0] slot_cnt,
    output logic             last_slot
);

    always_ff @(posedge clk) begin
        if (rst || clear || wrap) begin
            slot_cnt <= '0;
        end else if (load_one) begin
            slot_cnt <= SEL_W'(1);
        end else if (incr) begin
            slot_cnt <= slot_cnt + SEL_W'(1);
        end
    end

    assign last_slot = (slot_cnt == {SEL_W{1'b1}});

endmodule

// File: rtl/tdm_demux8.sv
// TDM receive demux: aligns on fsync, assembles NCH slots into a parallel word.
// Optional saturating violation counter under TDM_ERR_CNT_EN.
//
// state  | meaning
// HUNT   | not aligned; bits discarded until fsync seen
// LOCKED | aligned; slot_cnt tracks position within the frame
module tdm_demux8 import tdm_pkg::*; #(parameter int NCH = NCH_DEF) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux8_if.slave  bus
);

    localparam int SEL_W = $clog2(NCH);

    state_t           state, state_nx;
    logic [NCH-2:0]   frame_buf, frame_buf_nx;
    logic [NCH-1:0]   dout_q, dout_nx;
    logic             dout_valid_q, dout_valid_nx;
    logic             sync_err_q, sync_err_nx;
    logic [SEL_W-1:0] slot_cnt;
    logic             last_slot;
    logic             ctr_load_one, ctr_wrap, ctr_incr;

    tdm_slot_ctr #(.SEL_W(SEL_W)) u_slot_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .load_one  (ctr_load_one),
        .wrap      (ctr_wrap),
        .incr      (ctr_incr),
        .slot_cnt  (slot_cnt),
        .last_slot (last_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            frame_buf    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state        <= state_nx;
            frame_buf    <= frame_buf_nx;
            dout_q       <= dout_nx;
            dout_valid_q <= dout_valid_nx;
            sync_err_q   <= sync_err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        frame_buf_nx  = frame_buf;
        dout_nx       = dout_q;
        dout_valid_nx = 1'b0;
        sync_err_nx   = 1'b0;
        ctr_load_one  = 1'b0;
        ctr_wrap      = 1'b0;
        ctr_incr      = 1'b0;
        if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.fsync) begin
                        frame_buf_nx    = '0;
                        frame_buf_nx[0] = bus.din;
                        ctr_load_one    = 1'b1;
                        state_nx        = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.fsync) begin
                        // early sync restarts the frame on this bit
                        sync_err_nx     = (slot_cnt != '0);
                        frame_buf_nx    = '0;
                        frame_buf_nx[0] = bus.din;
                        ctr_load_one    = 1'b1;
                    end else if (slot_cnt == '0) begin
                        sync_err_nx = 1'b1;
                        state_nx    = HUNT;
                    end else if (last_slot) begin
                        dout_nx       = {bus.din, frame_buf};
                        dout_valid_nx = 1'b1;
                        ctr_wrap      = 1'b1;
                    end else begin
                        frame_buf_nx[slot_cnt] = bus.din;
                        ctr_incr               = 1'b1;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.locked     = (state == LOCKED);

`ifdef TDM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (sync_err_nx && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

endmodule
